// File: rtl/seq_det_param_if.sv
// Bus bundle for the programmable serial pattern detector: stream, config
// and counter controls in, match pulse and status out.
interface seq_det_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               data_in;
  logic               data_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap_en;
  logic               cnt_clr;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               cnt_sat;
  logic               cfg_err;

  modport master (
    output data_in, data_valid, cfg_load, pattern, pat_len, overlap_en, cnt_clr,
    input  detected, match_count, cnt_sat, cfg_err
  );

  modport slave (
    input  data_in, data_valid, cfg_load, pattern, pat_len, overlap_en, cnt_clr,
    output detected, match_count, cnt_sat, cfg_err
  );
endinterface

// File: rtl/seq_det_param.sv
// Run-time programmable serial pattern detector with overlap control,
// data-valid qualifier and a saturating match counter.
module seq_det_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] PAT_DEFAULT = 8'b0000_1101,
  parameter int                 LEN_DEFAULT = 4,
  parameter bit                 OVL_DEFAULT = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  seq_det_param_if.slave bus
);

  typedef enum logic [1:0] {DISABLED, FILLING, ARMED} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] hist, hist_nxt, pat_r, pat_nxt;
  logic [LEN_W-1:0]   fill, fill_nxt, len_r, len_nxt;
  logic               ovl_r, ovl_nxt;
  logic [MAX_LEN-1:0] hist_p0;
  logic [LEN_W-1:0]   fill_p0;
  logic               match_p0;
  logic               det_p1, det_nxt;
  logic               err_p1, err_nxt;
  logic [CNT_W-1:0]   cnt_p1, cnt_nxt, cnt_inc;
  logic               sat_p1, sat_nxt;

  function automatic logic len_ok(input logic [LEN_W-1:0] l);
    return (l != '0) && (int'(l) <= MAX_LEN);
  endfunction

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  always_comb begin
    // Stage p0: candidate history/fill after the current bit, match on that view
    hist_p0  = {hist[MAX_LEN-2:0], bus.data_in};
    fill_p0  = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
    match_p0 = (state != DISABLED) && bus.data_valid && !bus.cfg_load &&
               (fill_p0 >= len_r) &&
               (((hist_p0 ^ pat_r) & len_mask(len_r)) == '0);

    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    pat_nxt   = pat_r;
    len_nxt   = len_r;
    ovl_nxt   = ovl_r;
    err_nxt   = err_p1;
    det_nxt   = 1'b0;

    if (bus.cfg_load) begin
      pat_nxt   = bus.pattern;
      len_nxt   = bus.pat_len;
      ovl_nxt   = bus.overlap_en;
      hist_nxt  = '0;
      fill_nxt  = '0;
      err_nxt   = !len_ok(bus.pat_len);
      state_nxt = len_ok(bus.pat_len) ? FILLING : DISABLED;
    end else if (state != DISABLED && bus.data_valid) begin
      det_nxt = match_p0;
      if (match_p0 && !ovl_r) begin
        hist_nxt  = '0;
        fill_nxt  = '0;
        state_nxt = FILLING;
      end else begin
        hist_nxt  = hist_p0;
        fill_nxt  = fill_p0;
        state_nxt = (fill_p0 >= len_r) ? ARMED : FILLING;
      end
    end

    cnt_inc = cnt_p1 + CNT_W'(1);
    cnt_nxt = cnt_p1;
    sat_nxt = sat_p1;
    if (bus.cnt_clr) begin
      cnt_nxt = '0;
      sat_nxt = 1'b0;
    end else if (match_p0 && !(&cnt_p1)) begin
      cnt_nxt = cnt_inc;
      sat_nxt = sat_p1 | (&cnt_inc);
    end
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FILLING;
      hist   <= '0;
      fill   <= '0;
      pat_r  <= PAT_DEFAULT;
      len_r  <= LEN_W'(LEN_DEFAULT);
      ovl_r  <= OVL_DEFAULT;
      det_p1 <= 1'b0;
      err_p1 <= 1'b0;
      cnt_p1 <= '0;
      sat_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      hist   <= hist_nxt;
      fill   <= fill_nxt;
      pat_r  <= pat_nxt;
      len_r  <= len_nxt;
      ovl_r  <= ovl_nxt;
      det_p1 <= det_nxt;
      err_p1 <= err_nxt;
      cnt_p1 <= cnt_nxt;
      sat_p1 <= sat_nxt;
    end
  end

  assign bus.detected    = det_p1;
  assign bus.match_count = cnt_p1;
  assign bus.cnt_sat     = sat_p1;
  assign bus.cfg_err     = err_p1;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: default detector plus a 2-bit-counter
// instance for saturation behaviour.
module tb_seq_det_param;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_det_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus0 ();
  seq_det_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) bus1 ();

  seq_det_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset_n), .bus(bus0)
  );
  seq_det_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset_n), .bus(bus1)
  );

  task automatic idle();
    bus0.data_in = 1'b0; bus0.data_valid = 1'b0; bus0.cfg_load = 1'b0;
    bus0.pattern = '0;   bus0.pat_len = '0;      bus0.overlap_en = 1'b0;
    bus0.cnt_clr = 1'b0;
    bus1.data_in = 1'b0; bus1.data_valid = 1'b0; bus1.cfg_load = 1'b0;
    bus1.pattern = '0;   bus1.pat_len = '0;      bus1.overlap_en = 1'b0;
    bus1.cnt_clr = 1'b0;
  endtask

  task automatic send0(input logic b, input logic v, output logic det);
    bus0.data_in    = b;
    bus0.data_valid = v;
    @(negedge clk);
    det = bus0.detected;
    bus0.data_valid = 1'b0;
  endtask

  task automatic cfg0(input logic [7:0] pat, input logic [3:0] len,
                      input logic ovl, input logic coincident);
    bus0.cfg_load   = 1'b1;
    bus0.pattern    = pat;
    bus0.pat_len    = len;
    bus0.overlap_en = ovl;
    bus0.data_in    = 1'b1;
    bus0.data_valid = coincident;
    @(negedge clk);
    bus0.cfg_load   = 1'b0;
    bus0.data_valid = 1'b0;
  endtask

  task automatic cfg1(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    bus1.cfg_load   = 1'b1;
    bus1.pattern    = pat;
    bus1.pat_len    = len;
    bus1.overlap_en = ovl;
    @(negedge clk);
    bus1.cfg_load   = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus0.detected !== 1'b0) begin bad++; $display("FAIL rst_det got=%b want=0", bus0.detected); end
    total++; if (bus0.match_count !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", bus0.match_count); end
    total++; if (bus0.cnt_sat !== 1'b0) begin bad++; $display("FAIL rst_sat got=%b want=0", bus0.cnt_sat); end
    total++; if (bus0.cfg_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus0.cfg_err); end
    total++; if (bus1.match_count !== 2'd0) begin bad++; $display("FAIL rst_cnt1 got=%0d want=0", bus1.match_count); end
    reset_n = 1'b1;
  endtask

  task automatic test_default_overlap();
    logic [6:0] bits = 7'b1101101;
    logic [6:0] exp  = 7'b0001001;
    logic d;
    for (int i = 6; i >= 0; i--) begin
      send0(bits[i], 1'b1, d);
      total++; if (d !== exp[i]) begin bad++; $display("FAIL ovl_det[%0d] got=%b want=%b", 6 - i, d, exp[i]); end
    end
    total++; if (bus0.match_count !== 8'd2) begin bad++; $display("FAIL ovl_cnt got=%0d want=2", bus0.match_count); end
  endtask

  task automatic test_non_overlap();
    logic [6:0] bits = 7'b1101101;
    logic [6:0] exp  = 7'b0001000;
    logic d;
    cfg0(8'h0D, 4'd4, 1'b0, 1'b0);
    total++; if (bus0.cfg_err !== 1'b0) begin bad++; $display("FAIL novl_err got=%b want=0", bus0.cfg_err); end
    for (int i = 6; i >= 0; i--) begin
      send0(bits[i], 1'b1, d);
      total++; if (d !== exp[i]) begin bad++; $display("FAIL novl_det[%0d] got=%b want=%b", 6 - i, d, exp[i]); end
    end
    total++; if (bus0.match_count !== 8'd3) begin bad++; $display("FAIL novl_cnt got=%0d want=3", bus0.match_count); end
  endtask

  task automatic test_valid_gaps();
    logic [9:0] bits = 10'b1011001111;
    logic [9:0] vld  = 10'b1101110111;
    logic [9:0] exp  = 10'b0000000001;
    logic d;
    cfg0(8'hA7, 4'd8, 1'b1, 1'b0);
    for (int i = 9; i >= 0; i--) begin
      send0(bits[i], vld[i], d);
      total++; if (d !== exp[i]) begin bad++; $display("FAIL gap_det[%0d] got=%b want=%b", 9 - i, d, exp[i]); end
    end
    total++; if (bus0.match_count !== 8'd4) begin bad++; $display("FAIL gap_cnt got=%0d want=4", bus0.match_count); end
  endtask

  task automatic test_cfg_err();
    logic [7:0] junk = 8'b0101_1101;
    logic [4:0] bits = 5'b10101;
    logic [4:0] exp  = 5'b00101;
    logic d;
    cfg0(8'h00, 4'd0, 1'b1, 1'b0);
    total++; if (bus0.cfg_err !== 1'b1) begin bad++; $display("FAIL err_len0 got=%b want=1", bus0.cfg_err); end
    for (int i = 7; i >= 0; i--) begin
      send0(junk[i], 1'b1, d);
      total++; if (d !== 1'b0) begin bad++; $display("FAIL err0_det[%0d] got=%b want=0", 7 - i, d); end
    end
    cfg0(8'h05, 4'd9, 1'b1, 1'b0);
    total++; if (bus0.cfg_err !== 1'b1) begin bad++; $display("FAIL err_len9 got=%b want=1", bus0.cfg_err); end
    for (int i = 4; i >= 0; i--) begin
      send0(bits[i], 1'b1, d);
      total++; if (d !== 1'b0) begin bad++; $display("FAIL err9_det[%0d] got=%b want=0", 4 - i, d); end
    end
    total++; if (bus0.match_count !== 8'd4) begin bad++; $display("FAIL err_cnt got=%0d want=4", bus0.match_count); end
    // A 1 presented alongside cfg_load must be dropped, so 0,1 cannot complete 101
    cfg0(8'h05, 4'd3, 1'b1, 1'b1);
    total++; if (bus0.cfg_err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b want=0", bus0.cfg_err); end
    send0(1'b0, 1'b1, d);
    send0(1'b1, 1'b1, d);
    total++; if (d !== 1'b0) begin bad++; $display("FAIL cfg_prio got=%b want=0", d); end
    cfg0(8'h05, 4'd3, 1'b1, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      send0(bits[i], 1'b1, d);
      total++; if (d !== exp[i]) begin bad++; $display("FAIL len3_det[%0d] got=%b want=%b", 4 - i, d, exp[i]); end
    end
    total++; if (bus0.match_count !== 8'd6) begin bad++; $display("FAIL len3_cnt got=%0d want=6", bus0.match_count); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       exp_sat [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] nov_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic       nov_det [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] nov_bit = 4'b1110;
    cfg1(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus1.data_in = 1'b1; bus1.data_valid = 1'b1;
      @(negedge clk);
      total++; if (bus1.detected !== 1'b1) begin bad++; $display("FAIL sat_det[%0d] got=%b want=1", i, bus1.detected); end
      total++; if (bus1.match_count !== exp_cnt[i]) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", i, bus1.match_count, exp_cnt[i]); end
      total++; if (bus1.cnt_sat !== exp_sat[i]) begin bad++; $display("FAIL sat_flag[%0d] got=%b want=%b", i, bus1.cnt_sat, exp_sat[i]); end
    end
    bus1.cnt_clr = 1'b1;
    @(negedge clk);
    bus1.cnt_clr = 1'b0; bus1.data_valid = 1'b0;
    total++; if (bus1.match_count !== 2'd0) begin bad++; $display("FAIL clr_cnt got=%0d want=0", bus1.match_count); end
    total++; if (bus1.cnt_sat !== 1'b0) begin bad++; $display("FAIL clr_sat got=%b want=0", bus1.cnt_sat); end
    total++; if (bus1.detected !== 1'b1) begin bad++; $display("FAIL clr_det got=%b want=1", bus1.detected); end
    // Upper pattern bits must not matter for a 1-bit pattern
    cfg1(8'hA5, 4'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus1.data_in = nov_bit[3 - i]; bus1.data_valid = 1'b1;
      @(negedge clk);
      total++; if (bus1.detected !== nov_det[i]) begin bad++; $display("FAIL nov1_det[%0d] got=%b want=%b", i, bus1.detected, nov_det[i]); end
      total++; if (bus1.match_count !== nov_cnt[i]) begin bad++; $display("FAIL nov1_cnt[%0d] got=%0d want=%0d", i, bus1.match_count, nov_cnt[i]); end
    end
    bus1.data_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [2:0] pre  = 3'b110;
    logic [4:0] bits = 5'b11101;
    logic [4:0] exp  = 5'b00001;
    logic d;
    cfg0(8'h0D, 4'd4, 1'b1, 1'b0);
    for (int i = 2; i >= 0; i--) send0(pre[i], 1'b1, d);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (bus0.match_count !== 8'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d want=0", bus0.match_count); end
    reset_n = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      send0(bits[i], 1'b1, d);
      total++; if (d !== exp[i]) begin bad++; $display("FAIL mid_det[%0d] got=%b want=%b", 4 - i, d, exp[i]); end
    end
    total++; if (bus0.match_count !== 8'd1) begin bad++; $display("FAIL mid_cnt got=%0d want=1", bus0.match_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_default_overlap();
    test_non_overlap();
    test_valid_gaps();
    test_cfg_err();
    test_saturation();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised, run-time-programmable serial pattern detector. Successor to the fixed 4-bit overlapping "1101" detector.
Adds programmable pattern and length, an overlap/non-overlap mode, a data-valid qualifier, and a saturating match counter.
Sits on a serial bit stream and feeds a match pulse plus a count to downstream control/status logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
LEN_W, 4, width of pat_len; must hold MAX_LEN (clog2(MAX_LEN+1))
CNT_W, 8, width of match_count
PAT_DEFAULT, 8'b0000_1101, pattern loaded at reset (LSB-aligned)
LEN_DEFAULT, 4, pattern length loaded at reset
OVL_DEFAULT, 1, overlap mode loaded at reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low (0 = reset asserted)
data_in  in  1  serial data bit
data_valid  in  1  data_in sampled only when 1
cfg_load  in  1  latch pattern/pat_len/overlap_en; clears detection history
pattern  in  MAX_LEN  pattern bits; pattern[pat_len-1] arrives first, pattern[0] arrives last
pat_len  in  LEN_W  pattern length, valid range 1..MAX_LEN
overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  in  1  synchronous clear of match_count and cnt_sat
detected  out  1  registered one-cycle match pulse
match_count  out  CNT_W  number of matches, saturating
cnt_sat  out  1  sticky flag: match_count has reached all-ones
cfg_err  out  1  registered: active config has invalid length; detector disabled

Behaviour:
- Reset (reset=0, asynchronous):
  - Active config = PAT_DEFAULT / LEN_DEFAULT / OVL_DEFAULT.
  - history=0, fill=0, state=FILLING.
  - detected=0, match_count=0, cnt_sat=0, cfg_err=0.
  - Reset deassertion is synchronous to clk; the first sampled bit is on the first rising edge with reset=1.
- Internal state:
  - history: MAX_LEN shift register; new bit enters at bit 0.
  - fill: counter 0..MAX_LEN, saturates at MAX_LEN.
- FSM states:
  - DISABLED: active pat_len=0 or >MAX_LEN. No sampling, no matches, cfg_err=1.
  - FILLING: fill < pat_len.
  - ARMED: fill >= pat_len.
- Sampling edge (data_valid=1, not DISABLED):
  - history <= {history[MAX_LEN-2:0], data_in}; fill <= min(fill+1, MAX_LEN).
  - Match condition, evaluated on the updated value: new fill >= pat_len and the low pat_len bits of the new history equal the low pat_len bits of pattern.
  - On match, detected=1 for exactly the next cycle (registered: pulse visible in the cycle after the edge that sampled the last pattern bit).
- Overlap mode on match: history retained, so a pattern suffix can start the next match.
- Non-overlap mode on match: fill <= 0 and history <= 0, so the next match needs pat_len fresh bits.
- data_valid=0: history, fill, and state hold; detected=0 that cycle.
- cfg_load=1:
  - Latch pattern, pat_len, overlap_en; history<=0; fill<=0; detected<=0.
  - Next state = DISABLED if the new pat_len is invalid, else FILLING.
  - cfg_load has priority over a coincident data_valid; that bit is dropped.
  - match_count is unaffected.
- match_count:
  - Increments by 1 per match.
  - Holds at 2^CNT_W-1; cnt_sat is set when the count reaches all-ones.
  - cnt_clr zeroes the count and cnt_sat; cnt_clr wins over a coincident match (result 0).
  - detected still pulses for that match.
- Pattern bits above pat_len are ignored in the comparison.
- pat_len=1 is legal: every sampled bit equal to pattern[0] is a match.
  - Overlap mode: back-to-back pulses.
  - Non-overlap mode: same result, since fill returns to 0 and refills in one bit.
- Reset mid-stream: all history lost, config returns to defaults.

Test Plan:
1. Defaults after reset (1101, overlap), stream 1,1,0,1,1,0,1 with data_valid=1 → detected pulses after bits 4 and 7; match_count=2.
2. cfg_load with pattern=1101, pat_len=4, overlap_en=0, same stream → single pulse after bit 4; bits 5-7 (1,0,1) give no match; match_count increments by 1.
3. cfg_load with pattern=8'b1010_0111, pat_len=8, stream 1,0,1,0,0,1,1,1 with data_valid=0 inserted after bits 2 and 5 → one pulse after bit 8; gaps do not break the match.
4. cfg_load with pat_len=0 → cfg_err=1, no pulses on any stream. Then cfg_load with pat_len=3, pattern=101 → cfg_err=0; stream 1,0,1,0,1 in overlap mode gives 2 pulses.
5. CNT_W=2, pat_len=1, pattern=1, stream of five 1s → count 1,2,3,3,3 with cnt_sat=1 from the third match. Then cnt_clr coincident with a match → count=0, cnt_sat=0, detected=1.
6. Reset asserted (0) after bits 1,1,0 of a 1101 stream, then released and 1 sent → no pulse. Then 1,1,0,1 → pulse.
